// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: funnels NUM_REQ requesters into a single FIFO write port.
// Only one word is in flight at a time; a word the FIFO does not acknowledge is rewritten.
module fifo_wr_arbiter #(
   parameter int FIFO_WIDTH = 16,
   parameter int NUM_REQ    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_full,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_overflow,
   output logic                          fifo_wr_en,
   output logic [FIFO_WIDTH-1:0]         fifo_data_in,
   output logic                          busy,
   output logic [15:0]                   wr_count,
   output logic [7:0]                    retry_count
);

   localparam int              PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W:0]  NUM_W = (PTR_W+1)'(NUM_REQ);

   typedef enum logic [1:0] {IDLE, WRITE, ACK, HOLD} state_e;

   state_e                r_state;
   logic [PTR_W-1:0]      r_owner;
   logic [PTR_W-1:0]      r_rr_ptr;
   logic [FIFO_WIDTH-1:0] r_data;
   logic [NUM_REQ-1:0]    r_gnt;
   logic                  r_wr_en;
   logic [15:0]           r_wr_count;
   logic [7:0]            r_retry_count;

   state_e                w_state_nxt;
   logic [PTR_W-1:0]      w_owner_nxt;
   logic [PTR_W-1:0]      w_rr_nxt;
   logic [FIFO_WIDTH-1:0] w_data_nxt;
   logic [NUM_REQ-1:0]    w_gnt_nxt;
   logic                  w_wr_en_nxt;
   logic [15:0]           w_wr_cnt_nxt;
   logic [7:0]            w_retry_nxt;

   logic [NUM_REQ-1:0]    w_elig;
   logic                  w_found;
   logic [PTR_W-1:0]      w_sel;
   logic [PTR_W:0]        w_idx;
   logic [PTR_W:0]        w_ptr_inc;
   logic [FIFO_WIDTH-1:0] w_sel_data;

   // Round-robin search starting at r_rr_ptr; a requester whose gnt is high this cycle is skipped.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_elig  = req & ~r_gnt;
      w_found = 1'b0;
      w_sel   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_idx >= NUM_W) begin
            w_idx = w_idx - NUM_W;
         end
         if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_idx[PTR_W-1:0];
         end
      end
   end

   assign w_sel_data = req_data[w_sel*FIFO_WIDTH +: FIFO_WIDTH];
   assign w_ptr_inc  = {1'b0, r_owner} + 1'b1;

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_rr_nxt     = r_rr_ptr;
      w_data_nxt   = r_data;
      w_gnt_nxt    = '0;
      w_wr_en_nxt  = 1'b0;
      w_wr_cnt_nxt = r_wr_count;
      w_retry_nxt  = r_retry_count;
      case (r_state)
         IDLE: begin
            if (!fifo_full && w_found) begin
               w_owner_nxt = w_sel;
               w_data_nxt  = w_sel_data;
               w_wr_en_nxt = 1'b1;
               w_state_nxt = WRITE;
            end
         end
         WRITE: w_state_nxt = ACK;
         ACK: begin
            // An ack wins over overflow; no ack at all is handled as an overflow.
            case ({fifo_wr_ack, fifo_overflow})
               2'b10, 2'b11: begin
                  w_gnt_nxt[r_owner] = 1'b1;
                  w_rr_nxt           = (w_ptr_inc == NUM_W) ? '0 : w_ptr_inc[PTR_W-1:0];
                  if (r_wr_count != 16'hFFFF) begin
                     w_wr_cnt_nxt = r_wr_count + 16'd1;
                  end
                  w_state_nxt = IDLE;
               end
               default: begin
                  if (r_retry_count != 8'hFF) begin
                     w_retry_nxt = r_retry_count + 8'd1;
                  end
                  w_state_nxt = HOLD;
               end
            endcase
         end
         HOLD: begin
            if (!fifo_full) begin
               w_wr_en_nxt = 1'b1;
               w_state_nxt = WRITE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      if (!rst_n) begin
         r_state       <= IDLE;
         r_owner       <= '0;
         r_rr_ptr      <= '0;
         r_data        <= '0;
         r_gnt         <= '0;
         r_wr_en       <= 1'b0;
         r_wr_count    <= '0;
         r_retry_count <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_owner       <= w_owner_nxt;
         r_rr_ptr      <= w_rr_nxt;
         r_data        <= w_data_nxt;
         r_gnt         <= w_gnt_nxt;
         r_wr_en       <= w_wr_en_nxt;
         r_wr_count    <= w_wr_cnt_nxt;
         r_retry_count <= w_retry_nxt;
      end
   end

   assign gnt          = r_gnt;
   assign fifo_wr_en   = r_wr_en;
   assign fifo_data_in = r_data;
   assign busy         = (r_state != IDLE);
   assign wr_count     = r_wr_count;
   assign retry_count  = r_retry_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a FIFO responder driven from a response queue, and a scoreboard
// of expected write words and grants filled as stimulus is applied.
module tb_fifo_wr_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   typedef enum logic [1:0] {R_ACK, R_OVF, R_NONE, R_BOTH} resp_e;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   gnt;
   logic           fifo_full;
   logic           fifo_wr_ack;
   logic           fifo_overflow;
   logic           fifo_wr_en;
   logic [W-1:0]   fifo_data_in;
   logic           busy;
   logic [15:0]    wr_count;
   logic [7:0]     retry_count;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req           (req),
      .req_data      (req_data),
      .gnt           (gnt),
      .fifo_full     (fifo_full),
      .fifo_wr_ack   (fifo_wr_ack),
      .fifo_overflow (fifo_overflow),
      .fifo_wr_en    (fifo_wr_en),
      .fifo_data_in  (fifo_data_in),
      .busy          (busy),
      .wr_count      (wr_count),
      .retry_count   (retry_count)
   );

   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] exp_wr_q[$];
   logic [N-1:0] exp_gnt_q[$];
   resp_e        resp_q[$];
   bit           prev_wr_en = 1'b0;
   bit           last_wr_en = 1'b0;
   bit           hold_req   = 1'b0;
   logic [15:0]  exp_wr_cnt = '0;
   logic [7:0]   exp_retry  = '0;
   logic [W-1:0] exp_d;
   logic [N-1:0] exp_g;
   logic [W-1:0] dat [N];

   // Scoreboard: every write and every grant the DUT produces is popped and compared.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (fifo_wr_en === 1'b1) begin
            checks++;
            if (last_wr_en) begin
               failures++;
               $display("FAIL sb_wr_en_spacing: fifo_wr_en=1 two cycles running at %0t, required a gap", $time);
            end
            checks++;
            if (exp_wr_q.size() == 0) begin
               failures++;
               $display("FAIL sb_write: got unexpected write data=%h, required no write", fifo_data_in);
            end else begin
               exp_d = exp_wr_q.pop_front();
               if (fifo_data_in !== exp_d) begin
                  failures++;
                  $display("FAIL sb_write: got data=%h, required %h", fifo_data_in, exp_d);
               end
            end
         end
         if (gnt !== '0) begin
            checks++;
            if (exp_gnt_q.size() == 0) begin
               failures++;
               $display("FAIL sb_gnt: got unexpected gnt=%b, required none", gnt);
            end else begin
               exp_g = exp_gnt_q.pop_front();
               if (gnt !== exp_g) begin
                  failures++;
                  $display("FAIL sb_gnt: got gnt=%b, required %b", gnt, exp_g);
               end
            end
         end
      end
      last_wr_en = (fifo_wr_en === 1'b1);
   end

   // One clock: FIFO answers the write seen one cycle earlier; granted requesters drop req.
   task automatic tick();
      resp_e r;
      @(negedge clk);
      fifo_wr_ack   = 1'b0;
      fifo_overflow = 1'b0;
      if (prev_wr_en) begin
         r = R_ACK;
         if (resp_q.size() > 0) r = resp_q.pop_front();
         fifo_wr_ack   = (r == R_ACK) || (r == R_BOTH);
         fifo_overflow = (r == R_OVF) || (r == R_BOTH);
      end
      prev_wr_en = (fifo_wr_en === 1'b1);
      if (!hold_req) req = req & ~gnt;
   endtask

   task automatic drain(input int max_cycles, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < max_cycles; c++) begin
         tick();
         if (busy === 1'b0 && req == '0 && exp_wr_q.size() == 0 && exp_gnt_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic set_data(input int i, input logic [W-1:0] d);
      req_data[i*W +: W] = d;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      req       = '0;
      hold_req  = 1'b0;
      fifo_full = 1'b0;
      tick();
      tick();
      rst_n      = 1'b1;
      exp_wr_cnt = '0;
      exp_retry  = '0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req       = '1;
      hold_req  = 1'b1;
      fifo_full = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (gnt !== '0 || fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: gnt=%b wr_en=%b busy=%b, required 0 0 0", gnt, fifo_wr_en, busy);
      end
      checks++;
      if (fifo_data_in !== '0) begin
         failures++;
         $display("FAIL reset_data: got %h, required 0000", fifo_data_in);
      end
      checks++;
      if (wr_count !== 16'd0 || retry_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_counters: wr=%h retry=%h, required 0 0", wr_count, retry_count);
      end
      rst_n    = 1'b1;
      req      = '0;
      hold_req = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      set_data(2, 16'hA5A5);
      req = 4'b0100;
      exp_wr_q.push_back(16'hA5A5);
      exp_gnt_q.push_back(4'b0100);
      exp_wr_cnt++;
      tick();
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'hA5A5) begin
         failures++;
         $display("FAIL single_write_c1: wr_en=%b data=%h, required 1 a5a5", fifo_wr_en, fifo_data_in);
      end
      tick();
      checks++;
      if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || gnt !== '0) begin
         failures++;
         $display("FAIL single_ack_c2: wr_en=%b busy=%b gnt=%b, required 0 1 0000", fifo_wr_en, busy, gnt);
      end
      tick();
      checks++;
      if (gnt !== 4'b0100 || wr_count !== exp_wr_cnt) begin
         failures++;
         $display("FAIL single_gnt_c3: gnt=%b wr_count=%0d, required 0100 %0d", gnt, wr_count, exp_wr_cnt);
      end
      drain(10, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL single_drain: busy=%b pending_wr=%0d pending_gnt=%0d, required idle and empty",
                  busy, exp_wr_q.size(), exp_gnt_q.size());
      end
   endtask

   task automatic test_all_req();
      bit   ok;
      logic exp_en;
      apply_reset();
      for (int i = 0; i < N; i++) set_data(i, dat[i]);
      hold_req = 1'b1;
      req      = '1;
      for (int g = 0; g < 5; g++) begin
         exp_wr_q.push_back(dat[g % N]);
         exp_gnt_q.push_back(4'b0001 << (g % N));
         exp_wr_cnt++;
      end
      for (int c = 1; c <= 15; c++) begin
         tick();
         exp_en = (c % 3 == 1);
         checks++;
         if (fifo_wr_en !== exp_en) begin
            failures++;
            $display("FAIL all_wr_en_rate: cycle %0d wr_en=%b, required %b", c, fifo_wr_en, exp_en);
         end
         if (c % 3 == 0) begin
            exp_g = 4'b0001 << ((c / 3 - 1) % N);
            checks++;
            if (gnt !== exp_g) begin
               failures++;
               $display("FAIL all_gnt_order: cycle %0d gnt=%b, required %b", c, gnt, exp_g);
            end
         end
      end
      hold_req = 1'b0;
      req      = '0;
      drain(10, ok);
      checks++;
      if (!ok || wr_count !== exp_wr_cnt) begin
         failures++;
         $display("FAIL all_final: drained=%0d wr_count=%0d, required 1 %0d", ok, wr_count, exp_wr_cnt);
      end
   endtask

   task automatic test_full_stall();
      bit ok;
      fifo_full = 1'b1;
      set_data(1, 16'h5A01);
      req = 4'b0010;
      exp_wr_q.push_back(16'h5A01);
      exp_gnt_q.push_back(4'b0010);
      exp_wr_cnt++;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: cycle %0d wr_en=%b busy=%b, required 0 0", c, fifo_wr_en, busy);
         end
      end
      fifo_full = 1'b0;
      tick();
      checks++;
      if (fifo_wr_en !== 1'b1) begin
         failures++;
         $display("FAIL stall_release: wr_en=%b one cycle after full fell, required 1", fifo_wr_en);
      end
      drain(10, ok);
      checks++;
      if (!ok || wr_count !== exp_wr_cnt) begin
         failures++;
         $display("FAIL stall_final: drained=%0d wr_count=%0d, required 1 %0d", ok, wr_count, exp_wr_cnt);
      end
   endtask

   task automatic test_overflow_retry();
      bit ok;
      set_data(3, 16'h3C3C);
      req = 4'b1000;
      resp_q.push_back(R_OVF);
      exp_wr_q.push_back(16'h3C3C);
      exp_wr_q.push_back(16'h3C3C);
      exp_gnt_q.push_back(4'b1000);
      exp_wr_cnt++;
      exp_retry++;
      tick();
      tick();
      fifo_full = 1'b1;
      for (int c = 3; c <= 6; c++) begin
         tick();
         checks++;
         if (fifo_wr_en !== 1'b0 || busy !== 1'b1 || gnt !== '0 || retry_count !== exp_retry) begin
            failures++;
            $display("FAIL ovf_hold: cycle %0d wr_en=%b busy=%b gnt=%b retry=%0d, required 0 1 0000 %0d",
                     c, fifo_wr_en, busy, gnt, retry_count, exp_retry);
         end
      end
      fifo_full = 1'b0;
      tick();
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_data_in !== 16'h3C3C) begin
         failures++;
         $display("FAIL ovf_rewrite: wr_en=%b data=%h, required 1 3c3c", fifo_wr_en, fifo_data_in);
      end
      tick();
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         failures++;
         $display("FAIL ovf_gnt: gnt=%b, required 1000", gnt);
      end
      drain(10, ok);
      checks++;
      if (!ok || wr_count !== exp_wr_cnt || retry_count !== exp_retry) begin
         failures++;
         $display("FAIL ovf_final: drained=%0d wr=%0d retry=%0d, required 1 %0d %0d",
                  ok, wr_count, retry_count, exp_wr_cnt, exp_retry);
      end
   endtask

   task automatic test_ack_flags();
      bit ok;
      set_data(0, 16'h0F0F);
      req = 4'b0001;
      resp_q.push_back(R_NONE);
      resp_q.push_back(R_BOTH);
      exp_wr_q.push_back(16'h0F0F);
      exp_wr_q.push_back(16'h0F0F);
      exp_gnt_q.push_back(4'b0001);
      exp_wr_cnt++;
      exp_retry++;
      drain(20, ok);
      checks++;
      if (!ok || wr_count !== exp_wr_cnt || retry_count !== exp_retry) begin
         failures++;
         $display("FAIL flags_final: drained=%0d wr=%0d retry=%0d, required 1 %0d %0d",
                  ok, wr_count, retry_count, exp_wr_cnt, exp_retry);
      end
   endtask

   task automatic test_deassert();
      bit ok;
      set_data(2, 16'h7777);
      req = 4'b0100;
      resp_q.push_back(R_OVF);
      exp_wr_q.push_back(16'h7777);
      exp_wr_q.push_back(16'h7777);
      exp_gnt_q.push_back(4'b0100);
      exp_wr_cnt++;
      exp_retry++;
      tick();
      req = '0;
      set_data(2, 16'h8888);
      drain(20, ok);
      checks++;
      if (!ok || wr_count !== exp_wr_cnt) begin
         failures++;
         $display("FAIL deassert_final: drained=%0d wr=%0d, required 1 %0d", ok, wr_count, exp_wr_cnt);
      end
   endtask

   task automatic test_reset_in_ack();
      bit ok;
      for (int i = 0; i < N; i++) set_data(i, dat[i]);
      hold_req = 1'b1;
      req      = '1;
      exp_wr_q.push_back(dat[3]);
      tick();
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_data_in !== dat[3]) begin
         failures++;
         $display("FAIL rst_ack_owner: wr_en=%b data=%h, required 1 %h", fifo_wr_en, fifo_data_in, dat[3]);
      end
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if (gnt !== '0 || fifo_wr_en !== 1'b0 || busy !== 1'b0 || fifo_data_in !== '0 ||
          wr_count !== 16'd0 || retry_count !== 8'd0) begin
         failures++;
         $display("FAIL rst_ack_clear: gnt=%b wr_en=%b busy=%b data=%h wr=%0d retry=%0d, required all 0",
                  gnt, fifo_wr_en, busy, fifo_data_in, wr_count, retry_count);
      end
      rst_n      = 1'b1;
      exp_wr_cnt = 16'd1;
      exp_retry  = 8'd0;
      exp_wr_q.push_back(dat[0]);
      exp_gnt_q.push_back(4'b0001);
      tick();
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_data_in !== dat[0]) begin
         failures++;
         $display("FAIL rst_restart_at_0: wr_en=%b data=%h, required 1 %h", fifo_wr_en, fifo_data_in, dat[0]);
      end
      hold_req = 1'b0;
      req      = '0;
      drain(10, ok);
      checks++;
      if (!ok || wr_count !== exp_wr_cnt) begin
         failures++;
         $display("FAIL rst_ack_final: drained=%0d wr=%0d, required 1 %0d", ok, wr_count, exp_wr_cnt);
      end
   endtask

   task automatic test_saturation();
      bit ok;
      force dut.r_wr_count = 16'hFFFE;
      tick();
      release dut.r_wr_count;
      for (int n = 0; n < 2; n++) begin
         set_data(1, 16'hE000 + 16'(n));
         req = 4'b0010;
         exp_wr_q.push_back(16'hE000 + 16'(n));
         exp_gnt_q.push_back(4'b0010);
         drain(20, ok);
         checks++;
         if (!ok || wr_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_wr_count: ack %0d drained=%0d wr=%h, required 1 ffff", n, ok, wr_count);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) dat[i] = 16'hC000 + 16'(i);
      rst_n         = 1'b0;
      req           = '0;
      req_data      = '0;
      fifo_full     = 1'b0;
      fifo_wr_ack   = 1'b0;
      fifo_overflow = 1'b0;
      test_reset();
      test_single();
      test_all_req();
      test_full_stall();
      test_overflow_retry();
      test_ack_flags();
      test_deassert();
      test_reset_in_ack();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
